// File: rtl/lvds_sram_pkg.sv
// Shared types and defaults for the LVDS capture-to-SRAM writer.
package lvds_sram_pkg;

    localparam int unsigned ADDR_W_DEF   = 14;
    localparam int unsigned SAMPLE_W_DEF = 16;
    localparam int unsigned BE_W         = 4;
    localparam int unsigned OVF_CNT_W    = 16;

    localparam logic [BE_W-1:0] BYTE_EN = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/lvds_sram_if.sv
// SRAM port-2 write bus driven by the capture writer.
interface lvds_sram_if #(
    parameter int unsigned ADDR_W = lvds_sram_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = 2 * lvds_sram_pkg::SAMPLE_W_DEF
);
    logic [ADDR_W-1:0]                 sram_address;
    logic [DATA_W-1:0]                 sram_writedata;
    logic [lvds_sram_pkg::BE_W-1:0]    sram_byteenable;
    logic                              sram_chipselect;
    logic                              sram_write;

    modport master (
        output sram_address,
        output sram_writedata,
        output sram_byteenable,
        output sram_chipselect,
        output sram_write
    );

    modport slave (
        input sram_address,
        input sram_writedata,
        input sram_byteenable,
        input sram_chipselect,
        input sram_write
    );
endinterface

// File: rtl/lvds_sram_writer_packer.sv
// Pairs consecutive samples into one word: first sample low, second sample high.
module lvds_sample_packer
    import lvds_sram_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  sample_en,
    input  logic [SAMPLE_W-1:0]   sample,
    output logic                  word_valid_c,
    output logic [2*SAMPLE_W-1:0] word_c
);

    logic                phase;
    logic [SAMPLE_W-1:0] held;

    // Phase 0 holds the sample, phase 1 completes the word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase <= 1'b0;
            held  <= '0;
        end else if (clear) begin
            phase <= 1'b0;
        end else if (sample_en) begin
            phase <= ~phase;
            if (!phase) begin
                held <= sample;
            end
        end
    end

    assign word_valid_c = sample_en && phase;
    assign word_c       = {sample, held};

endmodule

// File: rtl/lvds_sram_writer.sv
// Packs LVDS samples into a ping-pong SRAM buffer with per-half ready flags.
// Optional LVDS_SRAM_WR_OVF_COUNT_EN adds a saturating dropped-sample counter.
module lvds_sram_writer
    import lvds_sram_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned DATA_W   = 2 * SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    input  logic [1:0]          buf_ack,
    lvds_sram_if.master         sram,
    output logic [1:0]          buf_ready,
    output logic                irq,
    output logic                overflow
`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
    ,
    output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_nxt;

    logic                accept_c;
    logic                drop_c;
    logic                start_c;
    logic                stall_exit_c;
    logic                pack_clear_c;
    logic                word_valid_c;
    logic [DATA_W-1:0]   word_c;
    logic                cur_half_c;
    logic                half_done_c;
    logic [1:0]          set_c;
    logic [1:0]          ready_nxt_c;

    assign accept_c     = (state == FILL)  && enable && in_valid;
    assign drop_c       = (state == STALL) && enable && in_valid;
    assign start_c      = (state == IDLE)  && enable;
    assign cur_half_c   = addr[ADDR_W-1];
    assign stall_exit_c = (state == STALL) && buf_ack[cur_half_c];
    assign pack_clear_c = (state == IDLE) || stall_exit_c;
    assign half_done_c  = word_valid_c && (addr[ADDR_W-2:0] == '1);

    lvds_sample_packer #(
        .SAMPLE_W (SAMPLE_W)
    ) u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (pack_clear_c),
        .sample_en    (accept_c),
        .sample       (in_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Set beats a same-cycle ack on the same half.
    always_comb begin
        set_c = '0;
        if (half_done_c) begin
            set_c[cur_half_c] = 1'b1;
        end
        ready_nxt_c = (buf_ready & ~buf_ack) | set_c;
    end

    // Next-state and address; dropping enable always returns to IDLE.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        unique case (state)
            IDLE: begin
                addr_nxt = '0;
                if (enable) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (word_valid_c) begin
                    addr_nxt = addr + ADDR_W'(1);
                    if (half_done_c && buf_ready[~cur_half_c] && !buf_ack[~cur_half_c]) begin
                        state_nxt = STALL;
                    end
                end
            end
            STALL: begin
                if (stall_exit_c) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!enable) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    // Registered SRAM write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sram.sram_write      <= 1'b0;
            sram.sram_chipselect <= 1'b0;
            sram.sram_byteenable <= '0;
            sram.sram_address    <= '0;
            sram.sram_writedata  <= '0;
        end else begin
            sram.sram_write      <= word_valid_c;
            sram.sram_chipselect <= word_valid_c;
            sram.sram_byteenable <= word_valid_c ? BYTE_EN : '0;
            if (word_valid_c) begin
                sram.sram_address   <= addr;
                sram.sram_writedata <= word_c;
            end
        end
    end

    // Ready flags, irq and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_ready <= '0;
            irq       <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            buf_ready <= ready_nxt_c;
            irq       <= |ready_nxt_c;
            if (start_c) begin
                overflow <= 1'b0;
            end else if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_count <= '0;
        end else if (start_c) begin
            ovf_count <= '0;
        end else if (drop_c && (ovf_count != '1)) begin
            ovf_count <= ovf_count + OVF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_lvds_sram_writer.sv
// Scoreboard bench for lvds_sram_writer with ADDR_W=4 (two halves of 8 words).
module tb_lvds_sram_writer;
    import lvds_sram_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned SW    = 16;
    localparam int unsigned DW    = 32;
    localparam int          HALF  = 8;
    localparam int          DEPTH = 16;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] in_data;
    logic        in_valid;
    logic [1:0]  buf_ack;
    logic [1:0]  buf_ready;
    logic        irq;
    logic        overflow;
`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
    logic [15:0] ovf_count;
`endif

    always #5 clk = ~clk;

    lvds_sram_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

    lvds_sram_writer #(.ADDR_W(AW), .SAMPLE_W(SW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .buf_ack   (buf_ack),
        .sram      (sram),
        .buf_ready (buf_ready),
        .irq       (irq),
        .overflow  (overflow)
`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    int  n_total = 0;
    int  n_pass  = 0;
    bit  mon_en  = 1'b0;
    int  wr_count = 0;
    int  last_addr = -1;
    logic [31:0] last_data = '0;
    wr_t exp_q[$];

    // Reference model state
    bit          m_cap, m_stall, m_have, m_wr, m_ovf;
    int          m_addr, m_cnt;
    logic [15:0] m_lat;
    bit   [1:0]  m_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: capture session, ping-pong halves, stall on busy half.
    always @(posedge clk) begin : model
        bit [1:0] set;
        int h;
        set  = 2'b00;
        if (!reset_n) begin
            m_cap = 0; m_stall = 0; m_have = 0; m_addr = 0;
            m_rdy = 0; m_ovf = 0; m_cnt = 0; m_wr = 0;
        end else begin
            m_wr = 0;
            if (!enable) begin
                m_cap = 0; m_stall = 0; m_have = 0; m_addr = 0;
            end else if (!m_cap) begin
                m_cap = 1; m_ovf = 0; m_cnt = 0;
            end else if (m_stall) begin
                if (in_valid) begin
                    m_ovf = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
                if (buf_ack[m_addr / HALF]) begin
                    m_stall = 0; m_have = 0;
                end
            end else if (in_valid) begin
                if (!m_have) begin
                    m_lat  = in_data;
                    m_have = 1;
                end else begin
                    exp_q.push_back('{m_addr, {in_data, m_lat}});
                    m_wr   = 1;
                    m_have = 0;
                    if (m_addr % HALF == HALF - 1) begin
                        h = m_addr / HALF;
                        set[h] = 1'b1;
                        if (m_rdy[1-h] && !buf_ack[1-h]) m_stall = 1;
                    end
                    m_addr = (m_addr + 1) % DEPTH;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (set[i]) m_rdy[i] = 1'b1;
                else if (buf_ack[i]) m_rdy[i] = 1'b0;
            end
        end
    end

    // Monitor: compares every cycle against the model, pops writes from the scoreboard.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mon_en) begin
            chk("write_strobe", 32'(sram.sram_write), 32'(m_wr));
            if (sram.sram_write) begin
                wr_count++;
                last_addr = int'(sram.sram_address);
                last_data = sram.sram_writedata;
                chk("write_be", 32'(sram.sram_byteenable), 32'(BYTE_EN));
                chk("write_cs", 32'(sram.sram_chipselect), 32'd1);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h with empty scoreboard at %0t",
                             sram.sram_address, sram.sram_writedata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(sram.sram_address), 32'(e.addr));
                    chk("write_data", sram.sram_writedata, e.data);
                end
            end else begin
                if (m_wr && exp_q.size() != 0) void'(exp_q.pop_front());
                chk("idle_be", 32'(sram.sram_byteenable), 32'd0);
                chk("idle_cs", 32'(sram.sram_chipselect), 32'd0);
            end
            chk("buf_ready", 32'(buf_ready), 32'(m_rdy));
            chk("irq", 32'(irq), 32'(|m_rdy));
            chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
            chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
        end
    end

    task automatic step(input bit v, input logic [15:0] d, input logic [1:0] ack);
        in_valid = v;
        in_data  = d;
        buf_ack  = ack;
        @(negedge clk);
        in_valid = 1'b0;
        buf_ack  = 2'b00;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_write"}, 32'(sram.sram_write), 32'd0);
        chk({nm, "_cs"}, 32'(sram.sram_chipselect), 32'd0);
        chk({nm, "_be"}, 32'(sram.sram_byteenable), 32'd0);
        chk({nm, "_addr"}, 32'(sram.sram_address), 32'd0);
        chk({nm, "_data"}, sram.sram_writedata, 32'd0);
        chk({nm, "_ready"}, 32'(buf_ready), 32'd0);
        chk({nm, "_irq"}, 32'(irq), 32'd0);
        chk({nm, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int  base;
        bit  en_r;
        reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; buf_ack = '0;
        @(negedge clk);
        mon_en = 1'b1;
        step(0, 0, 0);
        chk_all_zero("reset");

        // First half: samples 1..16
        reset_n = 1'b1; enable = 1'b1;
        step(0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(1, 16'(i), 0);
            if (i == 2) begin
                chk("first_word_addr", 32'(sram.sram_address), 32'd0);
                chk("first_word_data", sram.sram_writedata, 32'h0002_0001);
            end
        end
        chk("half0_last_addr", 32'(sram.sram_address), 32'd7);
        chk("half0_ready", 32'(buf_ready), 32'd1);

        // Second half without ack, then one sample into STALL
        for (int i = 17; i <= 32; i++) step(1, 16'(i), 0);
        chk("half1_last_addr", 32'(sram.sram_address), 32'd15);
        chk("both_ready", 32'(buf_ready), 32'd3);
        step(1, 16'd33, 0);
        chk("stall_no_write", 32'(sram.sram_write), 32'd0);
        chk("stall_overflow", 32'(overflow), 32'd1);
`ifdef LVDS_SRAM_WR_OVF_COUNT_EN
        chk("stall_ovf_count", 32'(ovf_count), 32'd1);
`endif

        // Release half 0, resume at address 0
        step(0, 0, 2'b01);
        chk("ack_ready", 32'(buf_ready), 32'd2);
        step(1, 16'h00A1, 2'b10);
        step(1, 16'h00A2, 0);
        chk("resume_addr", 32'(sram.sram_address), 32'd0);
        chk("resume_data", sram.sram_writedata, 32'h00A2_00A1);

        // Fill to address 15 with a same-cycle ack on half 1
        for (int w = 1; w <= 15; w++) begin
            step(1, 16'(16'h0100 + 2*w), 0);
            step(1, 16'(16'h0101 + 2*w), (w == 15) ? 2'b10 : 2'b00);
        end
        chk("set_wins_ready", 32'(buf_ready), 32'd3);

        // Three samples then drop enable
        step(0, 0, 2'b01);
        base = wr_count;
        step(1, 16'h0011, 0);
        step(1, 16'h0022, 0);
        step(1, 16'h0033, 0);
        enable = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("disable_write_count", 32'(wr_count - base), 32'd1);
        chk("disable_write_addr", 32'(last_addr), 32'd0);
        enable = 1'b1;
        step(0, 0, 0);
        chk("reenable_ovf_clear", 32'(overflow), 32'd0);
        step(1, 16'h0044, 0);
        step(1, 16'h0055, 0);
        chk("reenable_addr", 32'(sram.sram_address), 32'd0);
        chk("reenable_data", sram.sram_writedata, 32'h0055_0044);

        // Reset right after a word-completing sample
        step(1, 16'h0066, 0);
        step(1, 16'h0077, 0);
        reset_n = 1'b0;
        step(0, 0, 0);
        chk_all_zero("midreset");
        step(0, 0, 0);
        chk("midreset_no_strobe", 32'(sram.sram_write), 32'd0);

        // Randomized traffic
        reset_n = 1'b1;
        en_r = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            enable  = en_r;
            reset_n = ($urandom_range(0, 1499) != 0);
            step($urandom_range(0, 9) < 8, 16'($urandom),
                 {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0)});
        end
        reset_n = 1'b1;
        enable  = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
